// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared definitions for the MEM pipeline stage: major opcodes of
//             memory instructions, the funct3 width/sign encoding and the
//             request FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Access width and signedness carried in instruction bits [14:12].
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Purpose  : Combinational load-data extraction. Shifts the returned memory
//             word down by the byte offset and sign- or zero-extends the
//             selected byte/halfword according to funct3.
//  Ports    : rdata  in  32  word returned by data memory
//             off    in   2  effective byte offset inside the word
//             funct3 in   3  load width/sign selector
//             data   out 32  extended load value
//  Revision : 1.0 - initial release
// ============================================================================
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  funct3_e     funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h000000, shifted[7:0]};
      F3_HU:   data = {16'h0000, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM pipeline stage. Decodes loads/stores from the EX/MEM
//             register, drives a request/ack data-memory port with byte-lane
//             enables and replicated store data, stalls upstream while the
//             memory is busy and registers the MEM/WB outputs.
//  Build    : MISALIGN_TRAP_EN defined   -> misaligned ops are suppressed and
//                                           flagged on misalign for one cycle
//             MISALIGN_TRAP_EN undefined -> misalign tied 0, halfword/word
//                                           accesses are force-aligned
//  Ports    : clk, rst (async, active-low)
//             alu_q, rd2q, pc4q, instq1     in  EX/MEM register contents
//             dmem_req/we/addr/be/wdata     out memory request
//             dmem_ack, dmem_rdata          in  memory response
//             stall                         out freeze upstream registers
//             wb_data, wb_pc4, wb_inst      out MEM/WB register
//             misalign                      out misaligned-access flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_q,
  input  logic [31:0] rd2q,
  input  logic [31:0] pc4q,
  input  logic [31:0] instq1,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc4,
  output logic [31:0] wb_inst,
  output logic        misalign
);

  logic [6:0]  opcode;
  funct3_e     f3;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic [1:0]  off;
  logic [1:0]  lane_off;
  logic        trap;
  logic [31:0] load_data;
  state_e      state;
  state_e      state_nxt;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign opcode = instq1[6:0];
  assign f3     = funct3_e'(instq1[14:12]);
  assign off    = alu_q[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == OP_LOAD) begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: is_load = 1'b1;
        default:                        is_load = 1'b0;
      endcase
    end else if (opcode == OP_STORE) begin
      case (f3)
        F3_B, F3_H, F3_W: is_store = 1'b1;
        default:          is_store = 1'b0;
      endcase
    end
  end

  assign mem_op  = is_load | is_store;
  assign is_half = (f3 == F3_H) || (f3 == F3_HU);
  assign is_word = (f3 == F3_W);

`ifdef MISALIGN_TRAP_EN
  // Misaligned ops never reach memory; lanes use the raw offset.
  assign lane_off = off;
  assign trap     = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
  // Low offset bits that would misalign the access are simply dropped.
  assign lane_off = is_word ? 2'b00 : (is_half ? {off[1], 1'b0} : off);
  assign trap     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mem_op && !trap && !dmem_ack) state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_ack)                     state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gated with rst so the request drops the instant reset asserts, even
  // while the held EX/MEM inputs still describe a memory op.
  assign dmem_req = rst & (((state == ST_IDLE) & mem_op & ~trap) |
                           (state == ST_WAIT));
  assign dmem_we  = dmem_req & is_store;
  assign stall    = dmem_req & ~dmem_ack;
  assign dmem_addr = {alu_q[31:2], 2'b00};

  // --------------------------------------------------------------------------
  // Byte lanes and store data
  // --------------------------------------------------------------------------
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = rd2q;
    if (is_load) begin
      dmem_be = 4'b1111;
    end else if (is_store) begin
      case (f3)
        F3_B: begin
          dmem_be    = 4'b0001 << lane_off;
          dmem_wdata = {4{rd2q[7:0]}};
        end
        F3_H: begin
          dmem_be    = 4'b0011 << lane_off;
          dmem_wdata = {2{rd2q[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = rd2q;
        end
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (lane_off),
    .funct3 (f3),
    .data   (load_data)
  );

  // --------------------------------------------------------------------------
  // MEM/WB register: a stalled cycle writes a bubble; a trapped op retires
  // as a null instruction carrying its faulting address.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data <= 32'h0;
      wb_pc4  <= 32'h0;
      wb_inst <= 32'h0;
    end else if (stall) begin
      wb_data <= 32'h0;
      wb_pc4  <= 32'h0;
      wb_inst <= 32'h0;
    end else begin
      wb_pc4  <= pc4q;
      wb_inst <= trap ? 32'h0 : instq1;
      wb_data <= (is_load && !trap) ? load_data : alu_q;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= trap;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule : mem_stage
`default_nettype wire
